// File: rtl/fifo_pkg.sv
// Shared types and the round-robin pick helper for the FIFO write arbiter.
// rr_pick works on a 16-bit request vector so one function serves any NUM_REQ up to 16.
package fifo_pkg;

    localparam int DEFAULT_WIDTH     = 8;
    localparam int DEFAULT_FIFO_SIZE = 16;
    localparam int MAX_REQ           = 16;

    typedef enum logic {ARB, LOCK} arb_state_t;

    // One-hot mask of the first set request found searching upward from last_idx+1, wrapping at n.
    function automatic logic [MAX_REQ-1:0] rr_pick(input logic [MAX_REQ-1:0] req,
                                                   input logic [3:0]         last_idx,
                                                   input int                 n);
        logic [MAX_REQ-1:0] pick;
        logic               found;
        int                 idx;
        pick  = '0;
        found = 1'b0;
        for (int k = 1; k <= MAX_REQ; k++) begin
            if (k <= n) begin
                idx = (int'(last_idx) + k) % n;
                if (!found && req[idx]) begin
                    pick[idx] = 1'b1;
                    found     = 1'b1;
                end
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/fifo_wr_arbiter_rr_arbiter.sv
// Round-robin pick plus the last-winner register; the pointer only moves on a real grant.
// Latency: grant is combinational; last_idx updates on the grant edge. Backpressure: en_i=0 suppresses all grants.
module rr_arbiter
    import fifo_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic               clk,
    input  logic               res,
    input  logic               en_i,
    input  logic [NUM_REQ-1:0] req_i,
    output logic [NUM_REQ-1:0] gnt_o,
    output logic [IDX_W-1:0]   last_idx_o
);

    logic [IDX_W-1:0]   last_idx_q;
    logic [IDX_W-1:0]   last_idx_d;
    logic [MAX_REQ-1:0] pick_full;
    logic               unused_pick;

    assign pick_full   = rr_pick(MAX_REQ'(req_i), 4'(last_idx_q), NUM_REQ);
    assign unused_pick = ^pick_full;
    assign gnt_o       = en_i ? pick_full[NUM_REQ-1:0] : '0;
    assign last_idx_o  = last_idx_q;

    always_comb begin
        last_idx_d = last_idx_q;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (gnt_o[i]) begin
                last_idx_d = IDX_W'(i);
            end
        end
    end

    // Reset parks the pointer on the top index so requester 0 wins first.
    always_ff @(posedge clk) begin
        if (res) begin
            last_idx_q <= IDX_W'(NUM_REQ - 1);
        end else begin
            last_idx_q <= last_idx_d;
        end
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port among NUM_REQ producers; optional burst lock via FIFO_BURST_LOCK_EN.
// Latency: zero, grant/wr_en/wdata combinational in the accept cycle. Backpressure: no grant while fifo_full or res.
module fifo_wr_arbiter
    import fifo_pkg::*;
#(
    parameter int WIDTH     = DEFAULT_WIDTH,
    parameter int NUM_REQ   = 4,
    parameter int MAX_BURST = 4,
    parameter int IDX_W     = $clog2(NUM_REQ)
) (
    input  logic                     clk,
    input  logic                     res,
    input  logic [NUM_REQ-1:0]       req,
    input  logic [NUM_REQ*WIDTH-1:0] req_wdata,
    output logic [NUM_REQ-1:0]       gnt,
    input  logic                     fifo_full,
    input  logic                     fifo_overflow,
    output logic                     fifo_wr_en,
    output logic [WIDTH-1:0]         fifo_wdata,
    output logic [IDX_W-1:0]         last_idx,
    output logic                     err
);

    logic [NUM_REQ-1:0] req_arb;
    logic               err_q;
    logic               err_d;

`ifdef FIFO_BURST_LOCK_EN
    arb_state_t state_q;
    logic [7:0] burst_cnt_q;

    // While locked only the current owner is visible to the picker.
    assign req_arb = (state_q == LOCK) ? (req & (NUM_REQ'(1) << last_idx)) : req;

    always_ff @(posedge clk) begin
        if (res) begin
            state_q     <= ARB;
            burst_cnt_q <= '0;
        end else begin
            case (state_q)
                ARB: begin
                    if (fifo_wr_en && (MAX_BURST > 1)) begin
                        state_q     <= LOCK;
                        burst_cnt_q <= 8'd1;
                    end
                end
                LOCK: begin
                    if (!fifo_full) begin
                        if (!req[last_idx]) begin
                            state_q     <= ARB;
                            burst_cnt_q <= '0;
                        end else if (burst_cnt_q + 8'd1 == 8'(MAX_BURST)) begin
                            state_q     <= ARB;
                            burst_cnt_q <= '0;
                        end else begin
                            burst_cnt_q <= burst_cnt_q + 8'd1;
                        end
                    end
                end
                default: begin
                    state_q     <= ARB;
                    burst_cnt_q <= '0;
                end
            endcase
        end
    end
`else
    localparam int UNUSED_MAX_BURST = MAX_BURST;
    assign req_arb = req;
`endif

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_rr (
        .clk        (clk),
        .res        (res),
        .en_i       (!res && !fifo_full),
        .req_i      (req_arb),
        .gnt_o      (gnt),
        .last_idx_o (last_idx)
    );

    assign fifo_wr_en = |gnt;

    always_comb begin
        fifo_wdata = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (gnt[i]) begin
                fifo_wdata = fifo_wdata | req_wdata[i*WIDTH +: WIDTH];
            end
        end
    end

    always_comb begin
        err_d = err_q | fifo_overflow;
    end

    always_ff @(posedge clk) begin
        if (res) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign err = err_q;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Bench for fifo_wr_arbiter: vector table, randomized run against a queue-free rule model, and lock sequences.
module tb_fifo_wr_arbiter;

    logic        clk = 1'b0;
    logic        res;
    logic [3:0]  req;
    logic [31:0] req_wdata;
    logic [3:0]  gnt;
    logic        fifo_full;
    logic        fifo_overflow;
    logic        fifo_wr_en;
    logic [7:0]  fifo_wdata;
    logic [1:0]  last_idx;
    logic        err;

    int checks   = 0;
    int failures = 0;

    fifo_wr_arbiter #(
        .WIDTH     (8),
        .NUM_REQ   (4),
        .MAX_BURST (3)
    ) dut (
        .clk           (clk),
        .res           (res),
        .req           (req),
        .req_wdata     (req_wdata),
        .gnt           (gnt),
        .fifo_full     (fifo_full),
        .fifo_overflow (fifo_overflow),
        .fifo_wr_en    (fifo_wr_en),
        .fifo_wdata    (fifo_wdata),
        .last_idx      (last_idx),
        .err           (err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       r;
        logic [3:0] rq;
        logic       f;
        logic       o;
        logic [3:0] eg;
        logic [7:0] ew;
        logic [1:0] el;
        logic       ee;
    } vec_t;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Drive one cycle, compare outputs mid-cycle, then advance past the clock edge.
    task automatic cyc(input string nm, input logic r, input logic [3:0] rq, input logic f,
                       input logic o, input logic [3:0] eg, input logic [7:0] ew,
                       input logic [1:0] el, input logic ee, input bit cl);
        res = r; req = rq; fifo_full = f; fifo_overflow = o;
        #4;
        chk({nm, ".gnt"}, 32'(gnt), 32'(eg));
        chk({nm, ".wr_en"}, 32'(fifo_wr_en), 32'(|eg));
        chk({nm, ".wdata"}, 32'(fifo_wdata), 32'(ew));
        chk({nm, ".err"}, 32'(err), 32'(ee));
        if (cl) chk({nm, ".last_idx"}, 32'(last_idx), 32'(el));
        @(posedge clk);
        #1;
    endtask

    initial begin
        vec_t       tbl[$];
        int         mlast;
        bit         merr;
        logic [3:0] pending;
        logic [7:0] dat[4];
        logic       r, f, o;
        logic [3:0] eg;
        logic [7:0] ew;
        int         w;

        res = 1'b1; req = 4'hF; fifo_full = 1'b0; fifo_overflow = 1'b0;
        req_wdata = 32'hA3A2A1A0;
        @(posedge clk);
        #1;

`ifndef FIFO_BURST_LOCK_EN
        tbl = '{
            '{1'b1, 4'hF, 1'b0, 1'b0, 4'h0, 8'h00, 2'd3, 1'b0},
            '{1'b1, 4'hF, 1'b0, 1'b0, 4'h0, 8'h00, 2'd3, 1'b0},
            '{1'b0, 4'hF, 1'b0, 1'b0, 4'h1, 8'hA0, 2'd3, 1'b0},
            '{1'b0, 4'hF, 1'b0, 1'b0, 4'h2, 8'hA1, 2'd0, 1'b0},
            '{1'b0, 4'hF, 1'b0, 1'b0, 4'h4, 8'hA2, 2'd1, 1'b0},
            '{1'b0, 4'hF, 1'b0, 1'b0, 4'h8, 8'hA3, 2'd2, 1'b0},
            '{1'b0, 4'hF, 1'b0, 1'b0, 4'h1, 8'hA0, 2'd3, 1'b0},
            '{1'b0, 4'hF, 1'b0, 1'b0, 4'h2, 8'hA1, 2'd0, 1'b0},
            '{1'b0, 4'hF, 1'b1, 1'b0, 4'h0, 8'h00, 2'd1, 1'b0},
            '{1'b0, 4'hF, 1'b1, 1'b0, 4'h0, 8'h00, 2'd1, 1'b0},
            '{1'b0, 4'hF, 1'b1, 1'b0, 4'h0, 8'h00, 2'd1, 1'b0},
            '{1'b0, 4'hF, 1'b0, 1'b0, 4'h4, 8'hA2, 2'd1, 1'b0},
            '{1'b0, 4'h5, 1'b0, 1'b0, 4'h1, 8'hA0, 2'd2, 1'b0},
            '{1'b0, 4'h5, 1'b0, 1'b0, 4'h4, 8'hA2, 2'd0, 1'b0},
            '{1'b0, 4'h5, 1'b0, 1'b0, 4'h1, 8'hA0, 2'd2, 1'b0},
            '{1'b0, 4'h5, 1'b0, 1'b0, 4'h4, 8'hA2, 2'd0, 1'b0},
            '{1'b0, 4'h0, 1'b0, 1'b0, 4'h0, 8'h00, 2'd2, 1'b0},
            '{1'b0, 4'h0, 1'b0, 1'b0, 4'h0, 8'h00, 2'd2, 1'b0},
            '{1'b0, 4'h8, 1'b0, 1'b0, 4'h8, 8'hA3, 2'd2, 1'b0},
            '{1'b0, 4'h8, 1'b0, 1'b0, 4'h8, 8'hA3, 2'd3, 1'b0},
            '{1'b0, 4'h0, 1'b0, 1'b1, 4'h0, 8'h00, 2'd3, 1'b0},
            '{1'b0, 4'h0, 1'b0, 1'b0, 4'h0, 8'h00, 2'd3, 1'b1},
            '{1'b0, 4'h2, 1'b1, 1'b0, 4'h0, 8'h00, 2'd3, 1'b1},
            '{1'b1, 4'hF, 1'b0, 1'b0, 4'h0, 8'h00, 2'd3, 1'b1},
            '{1'b0, 4'hF, 1'b0, 1'b0, 4'h1, 8'hA0, 2'd3, 1'b0}
        };
        foreach (tbl[i]) begin
            cyc($sformatf("vec%0d", i), tbl[i].r, tbl[i].rq, tbl[i].f, tbl[i].o,
                tbl[i].eg, tbl[i].ew, tbl[i].el, tbl[i].ee, 1'b1);
        end

        // Randomized producers that hold their word until granted.
        mlast   = 0;
        merr    = 1'b0;
        pending = 4'h0;
        for (int i = 0; i < 4; i++) dat[i] = 8'($urandom);
        for (int c = 0; c < 400; c++) begin
            r = ($urandom_range(0, 39) == 0);
            f = ($urandom_range(0, 3) == 0);
            o = ($urandom_range(0, 49) == 0);
            pending = pending | 4'($urandom);
            req_wdata = {dat[3], dat[2], dat[1], dat[0]};
            w  = -1;
            eg = 4'h0;
            ew = 8'h00;
            if (!r && !f) begin
                for (int k = 1; k <= 4; k++) begin
                    if (w < 0 && pending[(mlast + k) % 4]) w = (mlast + k) % 4;
                end
            end
            if (w >= 0) begin
                eg[w] = 1'b1;
                ew    = dat[w];
            end
            cyc($sformatf("rnd%0d", c), r, pending, f, o, eg, ew, 2'(mlast), merr, 1'b1);
            if (r) begin
                mlast = 3;
                merr  = 1'b0;
            end else begin
                if (w >= 0) begin
                    mlast      = w;
                    pending[w] = 1'b0;
                    dat[w]     = 8'($urandom);
                end
                if (o) merr = 1'b1;
            end
        end
`else
        cyc("lrst", 1'b1, 4'h3, 1'b0, 1'b0, 4'h0, 8'h00, 2'd3, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++)
            cyc($sformatf("lock0_%0d", i), 1'b0, 4'h3, 1'b0, 1'b0, 4'h1, 8'hA0, 2'd0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++)
            cyc($sformatf("lock1_%0d", i), 1'b0, 4'h3, 1'b0, 1'b0, 4'h2, 8'hA1, 2'd0, 1'b0, 1'b0);
        cyc("relock0", 1'b0, 4'h3, 1'b0, 1'b0, 4'h1, 8'hA0, 2'd1, 1'b0, 1'b1);
        cyc("drop_idle", 1'b0, 4'h2, 1'b0, 1'b0, 4'h0, 8'h00, 2'd0, 1'b0, 1'b1);
        cyc("drop_next", 1'b0, 4'h2, 1'b0, 1'b0, 4'h2, 8'hA1, 2'd0, 1'b0, 1'b1);
        cyc("lock_full", 1'b0, 4'h3, 1'b1, 1'b0, 4'h0, 8'h00, 2'd1, 1'b0, 1'b1);
        cyc("lock_hold", 1'b0, 4'h3, 1'b0, 1'b0, 4'h2, 8'hA1, 2'd1, 1'b0, 1'b1);
        cyc("lock_rst", 1'b1, 4'h3, 1'b0, 1'b0, 4'h0, 8'h00, 2'd1, 1'b0, 1'b1);
        cyc("post_rst", 1'b0, 4'h3, 1'b0, 1'b1, 4'h1, 8'hA0, 2'd3, 1'b0, 1'b1);
        cyc("err_set", 1'b0, 4'h0, 1'b0, 1'b0, 4'h0, 8'h00, 2'd0, 1'b1, 1'b1);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
